// File: rtl/wb_pkg.sv
// Shared constants, types and helpers for the result write-back arbiter.
// Requester order is ALU0, ALU1, LSU, MUL; two register-file write ports.
package wb_pkg;

   localparam int NREQ   = 4;
   localparam int XLEN   = 32;
   localparam int NWP    = 2;
   localparam int REG_AW = 5;

   localparam int REQ_ALU0 = 0;
   localparam int REQ_ALU1 = 1;
   localparam int REQ_LSU  = 2;
   localparam int REQ_MUL  = 3;

   // Keeps the pointer at least one bit wide so a single-requester build still elaborates.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PTR_W = ptr_width(NREQ);

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating find-first-set: returns the first set bit of mask_i visiting
// start_i, start_i+1, ... modulo N.
module wb_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] start_i,
   output logic          found_o,
   output logic [PW-1:0] idx_o
);

   // Walk from the farthest offset back to the start so the nearest hit wins.
   always_comb begin
      int pos;
      pos     = 0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(start_i) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (mask_i[PW'(pos)]) begin
            found_o = 1'b1;
            idx_o   = PW'(pos);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: grants up to two result requesters per cycle
// onto two registered register-file write ports, avoiding same-rd double writes.
module wb_arbiter #(
   parameter int  NREQ = wb_pkg::NREQ,
   parameter int  XLEN = wb_pkg::XLEN,
   parameter int  NWP  = wb_pkg::NWP,
   localparam int AW   = wb_pkg::REG_AW,
   localparam int PW   = wb_pkg::ptr_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NWP-1:0]       wp_en,
   output logic [NWP*AW-1:0]    wp_addr,
   output logic [NWP*XLEN-1:0]  wp_data,
   output logic [PW-1:0]        rr_ptr
);

   import wb_pkg::*;

   logic [NREQ-1:0]          avail;
   logic [NREQ-1:0]          mask1;
   reg_addr_t                rd_arr   [NREQ];
   logic [XLEN-1:0]          data_arr [NREQ];
   logic                     found0;
   logic                     found1;
   logic [PW-1:0]            idx0;
   logic [PW-1:0]            idx1;
   reg_addr_t                rd0;

   logic [PW-1:0]            rr_ptr_q;
   logic [PW-1:0]            rr_ptr_d;
   logic [NWP-1:0]           wp_en_q;
   logic [NWP-1:0]           wp_en_d;
   logic [NWP-1:0][AW-1:0]   wp_addr_q;
   logic [NWP-1:0][AW-1:0]   wp_addr_d;
   logic [NWP-1:0][XLEN-1:0] wp_data_q;
   logic [NWP-1:0][XLEN-1:0] wp_data_d;

   // Reset and stall both remove every requester from consideration.
   assign avail = req_valid & {NREQ{rst & ~stall}};

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign rd_arr[gi]   = req_rd[gi*AW +: AW];
         assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
      end
   endgenerate

   wb_rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_pick0 (
      .mask_i  (avail),
      .start_i (rr_ptr_q),
      .found_o (found0),
      .idx_o   (idx0)
   );

   assign rd0 = rd_arr[idx0];

   // Port 1 skips the port-0 winner and anyone targeting the same nonzero rd.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mask1
         assign mask1[gi] = avail[gi]
                          & (idx0 != PW'(gi))
                          & ~((rd_arr[gi] == rd0) & (rd0 != '0));
      end
   endgenerate

   wb_rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_pick1 (
      .mask_i  (mask1),
      .start_i (rr_ptr_q),
      .found_o (found1),
      .idx_o   (idx1)
   );

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = (found0 & (idx0 == PW'(gi)))
                              | (found1 & (idx1 == PW'(gi)));
      end
   endgenerate

   always_comb begin
      wp_en_d   = '0;
      wp_addr_d = wp_addr_q;
      wp_data_d = wp_data_q;
      rr_ptr_d  = rr_ptr_q;
      if (found0) begin
         wp_en_d[0]   = (rd_arr[idx0] != '0);
         wp_addr_d[0] = rd_arr[idx0];
         wp_data_d[0] = data_arr[idx0];
         rr_ptr_d     = PW'(wrap_inc(int'(idx0), NREQ));
      end
      if (found1) begin
         wp_en_d[1]   = (rd_arr[idx1] != '0);
         wp_addr_d[1] = rd_arr[idx1];
         wp_data_d[1] = data_arr[idx1];
         rr_ptr_d     = PW'(wrap_inc(int'(idx1), NREQ));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_en_q   <= '0;
         wp_addr_q <= '0;
         wp_data_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         wp_en_q   <= wp_en_d;
         wp_addr_q <= wp_addr_d;
         wp_data_q <= wp_data_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign wp_en   = wp_en_q;
   assign wp_addr = wp_addr_q;
   assign wp_data = wp_data_q;
   assign rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant vectors checked combinationally,
// write-port results checked one edge later through a scoreboard queue.
module tb_wb_arbiter;

   localparam logic [31:0] DA = 32'hAAAA_0000;
   localparam logic [31:0] DB = 32'hBBBB_0001;
   localparam logic [31:0] DC = 32'hCCCC_0002;
   localparam logic [31:0] DD = 32'hDDDD_0003;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stall = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [4:0]   trd  [4];
   logic [31:0]  tdat [4];
   logic [19:0]  req_rd;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic [1:0]   wp_en;
   logic [9:0]   wp_addr;
   logic [63:0]  wp_data;
   logic [1:0]   rr_ptr;

   typedef struct {
      logic [1:0]  en;
      logic [1:0]  chk;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [1:0]  rr;
   } exp_t;

   exp_t       sb_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] seen_ready;
   int         cnt  [4];
   int         last [4];
   int         maxgap;

   assign req_rd   = {trd[3], trd[2], trd[1], trd[0]};
   assign req_data = {tdat[3], tdat[2], tdat[1], tdat[0]};

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wp_en     (wp_en),
      .wp_addr   (wp_addr),
      .wp_data   (wp_data),
      .rr_ptr    (rr_ptr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] r3);
      req_valid = v;
      trd[0] = r0;
      trd[1] = r1;
      trd[2] = r2;
      trd[3] = r3;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input logic [3:0] e_rdy, input logic [1:0] e_en, input logic [1:0] e_chk,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] e_rr);
      exp_t e;
      exp_t g;
      #1;
      seen_ready = req_ready;
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      e.en = e_en; e.chk = e_chk; e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1; e.rr = e_rr;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      chk("wp_en", 64'(wp_en), 64'(g.en));
      chk("rr_ptr", 64'(rr_ptr), 64'(g.rr));
      if (g.chk[0]) begin
         chk("wp_addr0", 64'(wp_addr[4:0]), 64'(g.a0));
         chk("wp_data0", 64'(wp_data[31:0]), 64'(g.d0));
      end
      if (g.chk[1]) begin
         chk("wp_addr1", 64'(wp_addr[9:5]), 64'(g.a1));
         chk("wp_data1", 64'(wp_data[63:32]), 64'(g.d1));
      end
      @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tdat[0] = DA; tdat[1] = DB; tdat[2] = DC; tdat[3] = DD;
      drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b0;
      #1;
      chk("rst_wp_en",   64'(wp_en),     64'd0);
      chk("rst_wp_addr", 64'(wp_addr),   64'd0);
      chk("rst_wp_data", 64'(wp_data),   64'd0);
      chk("rst_rr_ptr",  64'(rr_ptr),    64'd0);
      chk("rst_ready",   64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // All valid, distinct rd: two grants per cycle in rotation.
      cycle(4'b0011, 2'b11, 2'b11, 5'd1, DA, 5'd2, DB, 2'd2);
      cycle(4'b1100, 2'b11, 2'b11, 5'd3, DC, 5'd4, DD, 2'd0);

      // Stall freezes pointer, kills enables, ports hold last address/data.
      stall = 1'b1;
      repeat (3) cycle(4'b0000, 2'b00, 2'b11, 5'd3, DC, 5'd4, DD, 2'd0);
      stall = 1'b0;
      cycle(4'b0011, 2'b11, 2'b11, 5'd1, DA, 5'd2, DB, 2'd2);

      // Fairness over 8 continuous cycles.
      for (int i = 0; i < 4; i++) begin
         cnt[i]  = 0;
         last[i] = -1;
      end
      maxgap = 0;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) cycle(4'b1100, 2'b11, 2'b11, 5'd3, DC, 5'd4, DD, 2'd0);
         else            cycle(4'b0011, 2'b11, 2'b11, 5'd1, DA, 5'd2, DB, 2'd2);
         for (int i = 0; i < 4; i++) begin
            if (seen_ready[i]) begin
               if (k - last[i] - 1 > maxgap) maxgap = k - last[i] - 1;
               last[i] = k;
               cnt[i]++;
            end
         end
      end
      for (int i = 0; i < 4; i++) chk("fair_count", 64'(cnt[i]), 64'd4);
      chk("fair_gap_le2", 64'(maxgap <= 2), 64'd1);

      // Lone requester 3 with rd=0: handshake, no write, pointer wraps to 0.
      drive(4'b1000, 5'd0, 5'd0, 5'd0, 5'd0);
      cycle(4'b1000, 2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0);

      // Same rd on req0/req1: only req0 this cycle, req1 next.
      tdat[0] = 32'h11; tdat[1] = 32'h22;
      drive(4'b0011, 5'd5, 5'd5, 5'd0, 5'd0);
      cycle(4'b0001, 2'b01, 2'b01, 5'd5, 32'h11, 5'd0, 32'd0, 2'd1);
      drive(4'b0010, 5'd5, 5'd5, 5'd0, 5'd0);
      cycle(4'b0010, 2'b01, 2'b01, 5'd5, 32'h22, 5'd0, 32'd0, 2'd2);

      // Port 1 skips two conflicting candidates and takes req1.
      tdat[0] = 32'h100; tdat[1] = 32'h101; tdat[2] = 32'h102; tdat[3] = 32'h103;
      drive(4'b1111, 5'd7, 5'd8, 5'd7, 5'd7);
      cycle(4'b0110, 2'b11, 2'b11, 5'd7, 32'h102, 5'd8, 32'h101, 2'd2);

      // rd=0 on both is not a conflict: both granted, neither writes.
      drive(4'b1100, 5'd7, 5'd8, 5'd0, 5'd0);
      cycle(4'b1100, 2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0);

      // Single valid requester goes to port 0; then an idle cycle holds port 0.
      tdat[1] = 32'h99;
      drive(4'b0010, 5'd0, 5'd9, 5'd0, 5'd0);
      cycle(4'b0010, 2'b01, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 2'd2);
      drive(4'b0000, 5'd0, 5'd9, 5'd0, 5'd0);
      cycle(4'b0000, 2'b00, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 2'd2);

      // Reset pulsed between edges during traffic.
      tdat[0] = DA; tdat[1] = DB; tdat[2] = DC; tdat[3] = DD;
      drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
      #2 rst = 1'b0;
      #1;
      chk("midrst_wp_en",   64'(wp_en),     64'd0);
      chk("midrst_wp_addr", 64'(wp_addr),   64'd0);
      chk("midrst_wp_data", 64'(wp_data),   64'd0);
      chk("midrst_rr_ptr",  64'(rr_ptr),    64'd0);
      chk("midrst_ready",   64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("inrst_ready",  64'(req_ready), 64'd0);
      chk("inrst_wp_en",  64'(wp_en),     64'd0);
      chk("inrst_rr_ptr", 64'(rr_ptr),    64'd0);
      @(negedge clk);
      rst = 1'b1;
      cycle(4'b0011, 2'b11, 2'b11, 5'd1, DA, 5'd2, DB, 2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of result requesters (0 ALU0, 1 ALU1, 2 LSU, 3 MUL).
REQ-002 Parameter XLEN, default 32, result data width.
REQ-003 Parameter NWP, default 2, number of register-file write ports; fixed at 2 in this revision.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  when 1, no grants issued and no write ports enabled.
REQ-007 req_valid  input  NREQ  requester i holds a result.
REQ-008 req_rd  input  NREQ*5  destination register per requester.
REQ-009 req_data  input  NREQ*XLEN  result data per requester.
REQ-010 req_ready  output  NREQ  combinational grant; transfer when valid&ready.
REQ-011 wp_en  output  NWP  registered write enable per port.
REQ-012 wp_addr  output  NWP*5  registered write address per port.
REQ-013 wp_data  output  NWP*XLEN  registered write data per port.
REQ-014 rr_ptr  output  log2(NREQ)  current round-robin start index (debug/verification).

Function
REQ-015 Each cycle the block SHALL grant up to 2 valid requesters, searching in rotation order rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-016 Port 0 SHALL take the first valid requester in rotation order; port 1 the next valid one after it.
REQ-017 If the second candidate has the same req_rd as the first (and rd != 0), it SHALL NOT be granted that cycle; port 1 SHALL take the next non-conflicting valid requester, or stay idle.
REQ-018 req_ready[i] SHALL be 1 only for granted requesters; at most 2 bits set; all 0 when stall=1.
REQ-019 A requester with valid=1, ready=0 SHALL hold rd/data stable; the arbiter SHALL NOT depend on a requester dropping valid.
REQ-020 Latency: a grant in cycle N SHALL appear on wp_en/wp_addr/wp_data at the rising edge ending cycle N; 1-cycle registered latency.
REQ-021 Grant to a requester with req_rd=0 SHALL complete the handshake but drive wp_en=0 on its port.
REQ-022 Ports with no grant SHALL drive wp_en=0; wp_addr/wp_data SHALL hold their previous values.
REQ-023 rr_ptr SHALL advance to (index of last granted requester + 1) mod NREQ; no grant or stall leaves it unchanged.
REQ-024 Fairness: a continuously valid requester SHALL be granted within ceil(NREQ/2)+1 cycles of stall-free operation.
REQ-025 stall asserted mid-stream SHALL zero wp_en on the next edge and freeze rr_ptr; deassertion resumes from the frozen rr_ptr.
REQ-026 Only 1 valid requester: SHALL go to port 0; port 1 idle.

Reset
REQ-027 rst=0 SHALL immediately clear wp_en, wp_addr, wp_data and rr_ptr to 0 independent of clk.
REQ-028 While rst=0, req_ready SHALL be all 0.
REQ-029 First grant SHALL be possible in the first cycle after rst returns to 1; in-flight grants at reset are discarded.

Structure
REQ-030 Package wb_pkg SHALL hold NREQ, XLEN, NWP, REG_AW=5, PTR_W and the requester index constants.
REQ-031 Sub-module wb_rr_pick (rotating find-first-set over a mask from a start index, returns found flag and index) SHALL be instantiated twice: port 0 pick, then port 1 pick on the masked remainder.
REQ-032 All grant logic SHALL be combinational; only write-port outputs and rr_ptr are registers.

Verification
REQ-033 rr_ptr=0, all valid, rd={1,2,3,4}, data={A,B,C,D} -> ready=0011, next edge wp_en=11, addr={1,2}, data={A,B}, rr_ptr=2.
REQ-034 rr_ptr=0, valid=0011, rd0=rd1=5 -> ready=0001, port0 addr=5, wp_en=01; next cycle req1 granted, rr_ptr=2.
REQ-035 Only req3 valid rd=0 -> ready=1000, wp_en=00, rr_ptr=0.
REQ-036 All valid, stall=1 for 3 cycles -> ready=0000, wp_en=00, rr_ptr unchanged; stall=0 resumes from same rr_ptr.
REQ-037 All valid continuously for 8 cycles -> each requester granted exactly 4 times, no gap >2 cycles.
REQ-038 rst pulsed low between edges during traffic -> outputs and rr_ptr 0 immediately, ready=0000 until rst=1.
